// File: rtl/i2c_rx_sr_if.sv
// Pad-side and control-side signal bundle of the I2C slave receive shifter.
// master = pads/control FSM side, slave = the shifter itself.
interface i2c_rx_sr_if #(
  parameter int NUM_BITS = 8
);
  logic                scl_in;
  logic                sda_in;
  logic                rx_enable;
  logic                ack_enable;
  logic [NUM_BITS-1:0] parallel_out;
  logic                byte_valid;
  logic                start_det;
  logic                stop_det;
  logic                sda_pull;
  logic                busy;

  modport master (
    output scl_in, sda_in, rx_enable, ack_enable,
    input  parallel_out, byte_valid, start_det, stop_det, sda_pull, busy
  );

  modport slave (
    input  scl_in, sda_in, rx_enable, ack_enable,
    output parallel_out, byte_valid, start_det, stop_det, sda_pull, busy
  );
endinterface

// File: rtl/i2c_rx_sr.sv
// I2C slave receive shifter: sync SCL/SDA, detect START/STOP, shift bytes in, drive ACK; events seen SYNC_STAGES+1 clk after the pad.
// No backpressure: bytes are presented as a pulse; optional I2C_RX_GLITCH_FILTER_EN adds a 3-sample filter (+2 clk).
module i2c_rx_sr #(
  parameter int NUM_BITS    = 8,
  parameter int SHIFT_MSB   = 1,
  parameter int SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         rst,
  i2c_rx_sr_if.slave  bus
);

  localparam int            CW       = $clog2(NUM_BITS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NUM_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ACK   = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_raw;
  logic                   sda_raw;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_d;
  logic                   sda_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
    end
  end

  assign scl_raw = scl_sync[SYNC_STAGES-1];
  assign sda_raw = sda_sync[SYNC_STAGES-1];

`ifdef I2C_RX_GLITCH_FILTER_EN
  // Level follows the line only once the current and two previous samples agree.
  logic [1:0] scl_hist;
  logic [1:0] sda_hist;
  logic       scl_filt;
  logic       sda_filt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_hist <= '1;
      sda_hist <= '1;
      scl_filt <= 1'b1;
      sda_filt <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_raw};
      sda_hist <= {sda_hist[0], sda_raw};
      scl_filt <= scl_s;
      sda_filt <= sda_s;
    end
  end

  assign scl_s = (scl_raw == scl_hist[0] && scl_hist[0] == scl_hist[1]) ? scl_raw : scl_filt;
  assign sda_s = (sda_raw == sda_hist[0] && sda_hist[0] == sda_hist[1]) ? sda_raw : sda_filt;
`else
  assign scl_s = scl_raw;
  assign sda_s = sda_raw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  end

  logic scl_rise;
  logic scl_fall;
  logic start_c;
  logic stop_c;

  // SCL must be stable high across both samples, so a simultaneous SCL/SDA move is only a clock edge.
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start_c  = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_c   = scl_s & scl_d & ~sda_d & sda_s;

  state_t              state_q,    state_n;
  logic [CW-1:0]       bit_cnt_q,  bit_cnt_n;
  logic [NUM_BITS-1:0] shreg_q,    shreg_n;
  logic [NUM_BITS-1:0] pout_q,     pout_n;
  logic                bv_q,       bv_n;
  logic                sdet_q,     sdet_n;
  logic                pdet_q,     pdet_n;
  logic                pull_q,     pull_n;
  logic                ack_rise_q, ack_rise_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '1;
      pout_q     <= '1;
      bv_q       <= 1'b0;
      sdet_q     <= 1'b0;
      pdet_q     <= 1'b0;
      pull_q     <= 1'b0;
      ack_rise_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      bit_cnt_q  <= bit_cnt_n;
      shreg_q    <= shreg_n;
      pout_q     <= pout_n;
      bv_q       <= bv_n;
      sdet_q     <= sdet_n;
      pdet_q     <= pdet_n;
      pull_q     <= pull_n;
      ack_rise_q <= ack_rise_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    bit_cnt_n  = bit_cnt_q;
    shreg_n    = shreg_q;
    pout_n     = pout_q;
    bv_n       = 1'b0;
    sdet_n     = 1'b0;
    pdet_n     = 1'b0;
    pull_n     = pull_q;
    ack_rise_n = ack_rise_q;

    if (!bus.rx_enable) begin
      state_n    = IDLE;
      pull_n     = 1'b0;
      bit_cnt_n  = '0;
      ack_rise_n = 1'b0;
    end else if (start_c) begin
      // Covers both a fresh START and a repeated START; any partial byte is dropped.
      state_n    = SHIFT;
      sdet_n     = 1'b1;
      pull_n     = 1'b0;
      bit_cnt_n  = '0;
      shreg_n    = '1;
      ack_rise_n = 1'b0;
    end else if (stop_c) begin
      state_n    = IDLE;
      pdet_n     = 1'b1;
      pull_n     = 1'b0;
      bit_cnt_n  = '0;
      ack_rise_n = 1'b0;
    end else begin
      case (state_q)
        SHIFT: begin
          if (scl_rise && bit_cnt_q < CNT_FULL) begin
            if (SHIFT_MSB != 0) shreg_n = {shreg_q[NUM_BITS-2:0], sda_s};
            else                shreg_n = {sda_s, shreg_q[NUM_BITS-1:1]};
            bit_cnt_n = bit_cnt_q + 1'b1;
          end else if (scl_fall && bit_cnt_q == CNT_FULL) begin
            pout_n     = shreg_q;
            bv_n       = 1'b1;
            pull_n     = bus.ack_enable;
            ack_rise_n = 1'b0;
            state_n    = ACK;
          end
        end
        ACK: begin
          if (scl_rise) begin
            ack_rise_n = 1'b1;
          end else if (scl_fall && ack_rise_q) begin
            pull_n     = 1'b0;
            bit_cnt_n  = '0;
            shreg_n    = '1;
            ack_rise_n = 1'b0;
            state_n    = SHIFT;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign bus.parallel_out = pout_q;
  assign bus.byte_valid   = bv_q;
  assign bus.start_det    = sdet_q;
  assign bus.stop_det     = pdet_q;
  assign bus.sda_pull     = pull_q;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_rx_sr.sv
// Directed plus randomized bench for i2c_rx_sr; a byte-level model predicts received words and ACK levels.
module tb_i2c_rx_sr;
  localparam int NB        = 8;
  localparam int SHIFT_MSB = 1;
  localparam int W         = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_rx_sr_if #(.NUM_BITS(NB)) bus ();

  i2c_rx_sr #(.NUM_BITS(NB), .SHIFT_MSB(SHIFT_MSB), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int bv_cnt = 0;
  int st_cnt = 0;
  int sp_cnt = 0;
  logic [NB-1:0] got_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.byte_valid) begin
        bv_cnt++;
        got_q.push_back(bus.parallel_out);
      end
      if (bus.start_det) st_cnt++;
      if (bus.stop_det)  sp_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] exp_word(input logic [NB-1:0] b);
    logic [NB-1:0] r;
    if (SHIFT_MSB != 0) return b;
    for (int i = 0; i < NB; i++) r[i] = b[NB-1-i];
    return r;
  endfunction

  task automatic gap();
    repeat (W) @(negedge clk);
  endtask

  task automatic i2c_start();
    if (!(bus.scl_in && bus.sda_in)) begin
      bus.sda_in = 1'b1; gap();
      bus.scl_in = 1'b1; gap();
    end
    bus.sda_in = 1'b0; gap();
    bus.scl_in = 1'b0; gap();
  endtask

  task automatic i2c_stop();
    bus.sda_in = 1'b0; gap();
    bus.scl_in = 1'b1; gap();
    bus.sda_in = 1'b1; gap();
  endtask

  task automatic send_bit(input logic b);
    bus.sda_in = b;    gap();
    bus.scl_in = 1'b1; gap();
    bus.scl_in = 1'b0; gap();
  endtask

  // Sends one byte MSB-first plus the ACK clock; expect_rx says whether the slave should accept it.
  task automatic send_byte(input string tag, input logic [NB-1:0] b, input logic ack, input bit expect_rx);
    int bv0 = bv_cnt;
    bus.ack_enable = ack;
    for (int i = NB - 1; i >= 0; i--) send_bit(b[i]);
    chk({tag, "_bv"}, bv_cnt, expect_rx ? bv0 + 1 : bv0);
    if (expect_rx) chk({tag, "_data"}, got_q[$], exp_word(b));
    chk({tag, "_pull8"}, bus.sda_pull, expect_rx ? ack : 1'b0);
    bus.sda_in = 1'b1; gap();
    bus.scl_in = 1'b1; gap();
    chk({tag, "_pull9"}, bus.sda_pull, expect_rx ? ack : 1'b0);
    bus.scl_in = 1'b0; gap();
    chk({tag, "_pullrel"}, bus.sda_pull, 1'b0);
    chk({tag, "_busy"}, bus.busy, expect_rx ? 1'b1 : 1'b0);
  endtask

  initial begin
    logic [NB-1:0] rb;
    logic          ra;
    int            s0, p0, b0;

    bus.scl_in = 1'b1; bus.sda_in = 1'b1; bus.rx_enable = 1'b1; bus.ack_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pout", bus.parallel_out, {NB{1'b1}});
    chk("rst_pull", bus.sda_pull, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_pulses", {bus.byte_valid, bus.start_det, bus.stop_det}, 3'b000);
    rst = 1'b0;
    gap();

    // Single ACKed byte.
    s0 = st_cnt;
    i2c_start();
    chk("a5_start", st_cnt, s0 + 1);
    chk("a5_busy0", bus.busy, 1'b1);
    send_byte("a5", 8'hA5, 1'b1, 1'b1);

    // NACKed then ACKed byte, then STOP.
    send_byte("3c", 8'h3C, 1'b0, 1'b1);
    send_byte("81", 8'h81, 1'b1, 1'b1);
    p0 = sp_cnt;
    i2c_stop();
    chk("stop_det", sp_cnt, p0 + 1);
    chk("stop_busy", bus.busy, 1'b0);
    chk("stop_pout", bus.parallel_out, exp_word(8'h81));

    // Partial byte cut by repeated START.
    s0 = st_cnt; b0 = bv_cnt;
    i2c_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    i2c_start();
    chk("rs_nobv", bv_cnt, b0);
    chk("rs_starts", st_cnt, s0 + 2);
    send_byte("5a", 8'h5A, 1'b1, 1'b1);
    send_byte("12", 8'h12, 1'b1, 1'b1);
    i2c_stop();
    chk("12_pout", bus.parallel_out, exp_word(8'h12));
    chk("12_pull", bus.sda_pull, 1'b0);

    // Asynchronous reset in the middle of a byte.
    i2c_start();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_pout", bus.parallel_out, {NB{1'b1}});
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_pull", bus.sda_pull, 1'b0);
    @(negedge clk); rst = 1'b0;
    b0 = bv_cnt; s0 = st_cnt; p0 = sp_cnt;
    send_byte("postrst", 8'hC3, 1'b1, 1'b0);
    chk("postrst_start", st_cnt, s0);
    i2c_stop();
    chk("idle_stop", sp_cnt, p0 + 1);
    chk("idle_stop_busy", bus.busy, 1'b0);

    // Engine disarmed: nothing is reported, output retained.
    bus.rx_enable = 1'b0;
    gap();
    s0 = st_cnt; p0 = sp_cnt;
    i2c_start();
    send_byte("dis77", 8'h77, 1'b1, 1'b0);
    i2c_stop();
    chk("dis_start", st_cnt, s0);
    chk("dis_stop", sp_cnt, p0);
    chk("dis_pout", bus.parallel_out, {NB{1'b1}});
    bus.rx_enable = 1'b1;
    gap();

    // Randomized bytes and ACK choices.
    b0 = bv_cnt;
    i2c_start();
    for (int k = 0; k < 6; k++) begin
      rb = NB'($urandom_range(0, (1 << NB) - 1));
      ra = 1'($urandom_range(0, 1));
      send_byte("rnd", rb, ra, 1'b1);
    end
    i2c_stop();
    chk("rnd_count", bv_cnt, b0 + 6);

`ifdef I2C_RX_GLITCH_FILTER_EN
    // One-clock SCL spike while SCL is low must not clock in a bit.
    b0 = bv_cnt;
    i2c_start();
    bus.ack_enable = 1'b1;
    for (int i = NB - 1; i >= 0; i--) begin
      send_bit(rb[i]);
      if (i == 4) begin
        bus.scl_in = 1'b1; @(negedge clk);
        bus.scl_in = 1'b0; gap();
      end
    end
    chk("glitch_bv", bv_cnt, b0 + 1);
    chk("glitch_data", got_q[$], exp_word(rb));
    bus.sda_in = 1'b1; gap();
    bus.scl_in = 1'b1; gap();
    bus.scl_in = 1'b0; gap();
    i2c_stop();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_rx_sr.md
Name: i2c_rx_sr

Overview:
- Receive-side byte engine for the I2C slave; counterpart of the slave's parallel-to-serial transmit shifter.
- Synchronises raw SCL/SDA, detects START/STOP, shifts SDA in MSB-first on SCL rising edges, and presents each completed byte in parallel.
- Drives the open-drain ACK/NACK in the 9th clock.
- Sits between the slave pads and the slave control FSM / register interface.

Parameters:
- NUM_BITS, 8, data bits per transfer before the ACK slot.
- SHIFT_MSB, 1, 1 = first received bit lands in parallel_out[NUM_BITS-1]; 0 = first bit lands in bit 0.
- SYNC_STAGES, 2, flops in each SCL/SDA input synchroniser (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- scl_in  in  1  raw SCL from pad.
- sda_in  in  1  raw SDA from pad.
- rx_enable  in  1  1 = engine armed; 0 = forced to IDLE.
- ack_enable  in  1  sampled at byte completion: 1 = ACK (pull low), 0 = NACK (release).
- parallel_out  out  NUM_BITS  last completed byte; holds until the next completion.
- byte_valid  out  1  one-cycle pulse when parallel_out updates.
- start_det  out  1  one-cycle pulse on START or repeated START.
- stop_det  out  1  one-cycle pulse on STOP.
- sda_pull  out  1  1 = drive SDA low (open-drain enable).
- busy  out  1  1 in any state other than IDLE.

Behaviour:
- Reset (rst=1, asynchronous):
  - All synchroniser and previous-value flops set to 1 (idle bus).
  - parallel_out = all 1s. Internal shift register = all 1s.
  - byte_valid, start_det, stop_det, sda_pull, busy = 0. State = IDLE. bit_cnt = 0.
- Edge and condition detection, on synchronised scl_s/sda_s and their one-cycle delayed copies scl_d/sda_d:
  - scl_rise = scl_s & ~scl_d.
  - scl_fall = ~scl_s & scl_d.
  - START = scl_s & scl_d & sda_d & ~sda_s.
  - STOP = scl_s & scl_d & ~sda_d & sda_s.
  - Any raw-input event is seen SYNC_STAGES+1 clk cycles after the pad change.
- State IDLE:
  - Ignores SCL.
  - On START with rx_enable=1: go to SHIFT, bit_cnt=0, start_det=1 for one cycle.
- State SHIFT:
  - On scl_rise: shift sda_s in (direction per SHIFT_MSB); bit_cnt++.
  - On the first scl_fall with bit_cnt==NUM_BITS:
    - copy the shift register to parallel_out and pulse byte_valid in that same cycle;
    - set sda_pull = ack_enable (value sampled that cycle);
    - go to ACK.
- State ACK:
  - sda_pull is held stable through the whole 9th SCL pulse.
  - scl_rise in ACK does not shift.
  - On the next scl_fall after one scl_rise: sda_pull=0, bit_cnt=0, shift register reloaded to all 1s, go to SHIFT.
- Priority and boundary conditions:
  - START in SHIFT or ACK (repeated START):
    - Pulses start_det; sda_pull=0; bit_cnt=0; go to SHIFT.
    - Any partial byte is discarded; no byte_valid.
  - STOP in any non-IDLE state:
    - Pulses stop_det; sda_pull=0; go to IDLE.
    - Partial byte is discarded.
  - STOP seen while in IDLE still pulses stop_det.
  - rx_enable=0 overrides everything:
    - Next cycle: IDLE, sda_pull=0, no pulses.
    - parallel_out is retained.
  - SCL and SDA changing in the same synchronised cycle: treated as a clock edge only, never as START/STOP.
  - START and STOP are mutually exclusive by construction.
  - bit_cnt saturates at NUM_BITS; extra scl_rise beyond NUM_BITS before scl_fall is impossible by protocol and is ignored.

Optional Feature:
- Macro: I2C_RX_GLITCH_FILTER_EN.
- Defined:
  - Each synchronised line passes through a 3-sample majority/stability filter.
  - The filtered level changes only after 3 consecutive equal samples.
  - Adds 2 clk cycles of latency; pulses shorter than 3 clk are suppressed.
- Undefined:
  - Synchronised values are used directly.
  - Latency is SYNC_STAGES+1 cycles.

Test Plan:
- Reset mid-byte after 4 SCL rises -> immediately parallel_out=8'hFF, sda_pull=0, busy=0; subsequent bits ignored until a new START.
- START, send 0xA5 MSB-first, ack_enable=1 -> start_det pulse; byte_valid one pulse on the 8th scl_fall with parallel_out=8'hA5; sda_pull=1 until the 9th scl_fall; then busy=1, SHIFT.
- START, byte 0x3C with ack_enable=0, then byte 0x81 with ack_enable=1 -> parallel_out 8'h3C then 8'h81; sda_pull=0 during the 1st ACK slot and 1 during the 2nd.
- START, 5 bits 1,0,1,1,0, repeated START, byte 0x5A -> no byte_valid for the partial byte; start_det pulses twice; parallel_out=8'h5A.
- START, byte 0x12 ACKed, STOP -> stop_det pulse, busy=0, sda_pull=0; parallel_out stays 8'h12.
- rx_enable=0, START plus byte 0x77 -> no start_det, no byte_valid; sda_pull stays 0.
- With I2C_RX_GLITCH_FILTER_EN: 1-clk SCL glitch during a byte -> no extra shift.
